// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the debounced key code handed to the downstream decoder.
// The scanner uses the master view; the keypad/decoder side uses the slave view.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    input  row_in,
    output col_out, rows, columns, key_valid, key_strobe
  );

  modport slave (
    output row_in,
    input  col_out, rows, columns, key_valid, key_strobe
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, synchronizes the rows,
// debounces press and release, and presents one stable {rows, columns} code per keystroke.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_TARGET = 8'(DEBOUNCE_CNT);

  state_t      state, state_nxt;
  logic [3:0]  row_m, row_s;
  logic [15:0] div;
  logic        tick;
  logic        row_ok;
  logic [3:0]  col_adv;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  rel_cnt, rel_cnt_nxt;
  logic [3:0]  cand_row, cand_row_nxt;
  logic [3:0]  cand_col, cand_col_nxt;
  logic [3:0]  col, col_nxt;
  logic [3:0]  rows_q, rows_nxt;
  logic [3:0]  cols_q, cols_nxt;
  logic        valid_q, valid_nxt;
  logic        strobe_q, strobe_nxt;

  // Row pins are asynchronous; the divider free-runs regardless of state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      div   <= '0;
    end else begin
      row_m <= kp.row_in;
      row_s <= row_m;
      div   <= (div == DIV_LAST) ? 16'd0 : div + 16'd1;
    end
  end

  assign tick    = (div == DIV_LAST);
  assign row_ok  = $onehot(~row_s);
  assign col_adv = {col[2:0], col[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SCAN;
      cnt      <= '0;
      rel_cnt  <= '0;
      cand_row <= 4'hF;
      cand_col <= 4'hF;
      col      <= 4'b1110;
      rows_q   <= 4'hF;
      cols_q   <= 4'hF;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rel_cnt  <= rel_cnt_nxt;
      cand_row <= cand_row_nxt;
      cand_col <= cand_col_nxt;
      col      <= col_nxt;
      rows_q   <= rows_nxt;
      cols_q   <= cols_nxt;
      valid_q  <= valid_nxt;
      strobe_q <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rel_cnt_nxt  = rel_cnt;
    cand_row_nxt = cand_row;
    cand_col_nxt = cand_col;
    col_nxt      = col;
    rows_nxt     = rows_q;
    cols_nxt     = cols_q;
    valid_nxt    = valid_q;
    strobe_nxt   = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (row_ok) begin
            cand_row_nxt = row_s;
            cand_col_nxt = col;
            if (DEBOUNCE_CNT == 1) begin
              rows_nxt    = row_s;
              cols_nxt    = col;
              strobe_nxt  = 1'b1;
              valid_nxt   = 1'b1;
              rel_cnt_nxt = '0;
              state_nxt   = HELD;
            end else begin
              cnt_nxt   = 8'd1;
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col_adv;
          end
        end
        DEBOUNCE: begin
          // The column stays frozen, so only the candidate row needs comparing.
          if (row_s == cand_row) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt + 8'd1 == DB_TARGET) begin
              rows_nxt    = cand_row;
              cols_nxt    = cand_col;
              strobe_nxt  = 1'b1;
              valid_nxt   = 1'b1;
              rel_cnt_nxt = '0;
              state_nxt   = HELD;
            end
          end else begin
            col_nxt   = col_adv;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          if (row_s == 4'hF) begin
            rel_cnt_nxt = rel_cnt + 8'd1;
            if (rel_cnt + 8'd1 == DB_TARGET) begin
              rel_cnt_nxt = '0;
              valid_nxt   = 1'b0;
              col_nxt     = col_adv;
              state_nxt   = SCAN;
            end
          end else begin
            rel_cnt_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  assign kp.col_out    = col;
  assign kp.rows       = rows_q;
  assign kp.columns    = cols_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_strobe = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural keypad drives the rows from
// col_out, and a tick-level reference model predicts every output each cycle.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  rowDrive;

  int checks = 0;
  int errors = 0;
  int strobeSeen = 0;

  int         mColIdx;
  logic [3:0] mRows, mCols, candRow;
  bit         mValid, mStrobe, holding;
  int         pressStreak, relStreak;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c; a row reads low when its driven column is low.
  always_comb begin
    rowDrive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_out[c]) rowDrive[r] = 1'b0;
  end
  assign kif.row_in = rowDrive;

  function automatic logic [15:0] keyBit(input int r, input int c);
    return 16'd1 << (r*4 + c);
  endfunction

  function automatic logic [3:0] colCode(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] rowsFor(input logic [15:0] keys, input int idx);
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = ~keys[r*4+idx];
    return v;
  endfunction

  task automatic modelReset();
    mColIdx = 0; mRows = 4'hF; mCols = 4'hF; candRow = 4'hF;
    mValid = 0; mStrobe = 0; holding = 0; pressStreak = 0; relStreak = 0;
  endtask

  task automatic modelAccept();
    mRows = candRow; mCols = colCode(mColIdx);
    mValid = 1; mStrobe = 1; holding = 1; relStreak = 0; pressStreak = 0;
  endtask

  // One scan tick: what the keypad shows on the current column decides press/release progress.
  task automatic modelTick();
    logic [3:0] seen;
    seen = rowsFor(pressed, mColIdx);
    mStrobe = 0;
    if (holding) begin
      relStreak = (seen == 4'hF) ? relStreak + 1 : 0;
      if (relStreak == DB) begin
        holding = 0; mValid = 0; relStreak = 0;
        mColIdx = (mColIdx + 1) % 4;
      end
    end else if (pressStreak == 0) begin
      if ($countones(~seen) == 1) begin
        candRow = seen;
        pressStreak = 1;
        if (pressStreak == DB) modelAccept();
      end else begin
        mColIdx = (mColIdx + 1) % 4;
      end
    end else if (seen == candRow) begin
      pressStreak++;
      if (pressStreak == DB) modelAccept();
    end else begin
      pressStreak = 0;
      mColIdx = (mColIdx + 1) % 4;
    end
  endtask

  task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input bit expStrobe);
    if (kif.key_strobe === 1'b1) strobeSeen++;
    checkVal("col_out", kif.col_out, colCode(mColIdx));
    checkVal("rows", kif.rows, mRows);
    checkVal("columns", kif.columns, mCols);
    checkVal("key_valid", {3'b000, kif.key_valid}, {3'b000, mValid});
    checkVal("key_strobe", {3'b000, kif.key_strobe}, {3'b000, expStrobe});
  endtask

  // Called at the negedge of the first cycle of a tick period; holds keys for n periods.
  task automatic applyStimulus(input logic [15:0] keys, input int n);
    for (int p = 0; p < n; p++) begin
      checkOutput(mStrobe);
      pressed = keys;
      for (int k = 1; k < SCAN_DIV; k++) begin
        @(negedge clk);
        checkOutput(1'b0);
      end
      modelTick();
      @(negedge clk);
    end
  endtask

  task automatic resetPulse(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [15:0] keys;
    int          sel, col, r1, r2;

    modelReset();
    $display("[TB] reset and free scan");
    resetPulse(2);
    checkVal("rst_col_out", kif.col_out, 4'b1110);
    checkVal("rst_rows", kif.rows, 4'hF);
    checkVal("rst_columns", kif.columns, 4'hF);
    checkVal("rst_valid", {3'b000, kif.key_valid}, 4'h0);
    checkVal("rst_strobe", {3'b000, kif.key_strobe}, 4'h0);
    applyStimulus('0, 5);

    $display("[TB] clean press of key 6");
    strobeSeen = 0;
    applyStimulus(keyBit(1, 2), 8);
    checkVal("s2_rows", kif.rows, 4'b1101);
    checkVal("s2_columns", kif.columns, 4'b1011);
    checkVal("s2_valid", {3'b000, kif.key_valid}, 4'h1);
    checkCount("s2_strobes", strobeSeen, 1);
    applyStimulus('0, 4);

    $display("[TB] single-tick bounce");
    for (int i = 0; i < 4 && mColIdx != 0; i++) applyStimulus('0, 1);
    strobeSeen = 0;
    applyStimulus(keyBit(0, 0), 1);
    applyStimulus('0, 6);
    checkCount("s3_strobes", strobeSeen, 0);
    checkVal("s3_rows", kif.rows, 4'b1101);
    checkVal("s3_columns", kif.columns, 4'b1011);

    $display("[TB] hold then release key D");
    strobeSeen = 0;
    applyStimulus(keyBit(3, 3), 20);
    checkCount("s4_strobes", strobeSeen, 1);
    checkVal("s4_rows", kif.rows, 4'b0111);
    checkVal("s4_columns", kif.columns, 4'b0111);
    applyStimulus('0, 2);
    checkVal("s4_valid_2ticks", {3'b000, kif.key_valid}, 4'h1);
    applyStimulus('0, 1);
    checkVal("s4_valid_3ticks", {3'b000, kif.key_valid}, 4'h0);
    checkVal("s4_rows_kept", kif.rows, 4'b0111);
    checkVal("s4_columns_kept", kif.columns, 4'b0111);

    $display("[TB] two keys in one column");
    strobeSeen = 0;
    applyStimulus(keyBit(0, 0) | keyBit(1, 0), 12);
    checkCount("s5_strobes", strobeSeen, 0);
    checkVal("s5_valid", {3'b000, kif.key_valid}, 4'h0);
    applyStimulus('0, 2);

    $display("[TB] reset while held");
    strobeSeen = 0;
    applyStimulus(keyBit(2, 1), 8);
    checkCount("s6_strobes_pre", strobeSeen, 1);
    checkVal("s6_valid_pre", {3'b000, kif.key_valid}, 4'h1);
    resetPulse(1);
    checkVal("s6_rst_col_out", kif.col_out, 4'b1110);
    checkVal("s6_rst_rows", kif.rows, 4'hF);
    checkVal("s6_rst_valid", {3'b000, kif.key_valid}, 4'h0);
    checkVal("s6_rst_strobe", {3'b000, kif.key_strobe}, 4'h0);
    strobeSeen = 0;
    applyStimulus(keyBit(2, 1), 8);
    checkCount("s6_strobes_post", strobeSeen, 1);
    checkVal("s6_rows", kif.rows, 4'b1011);
    checkVal("s6_columns", kif.columns, 4'b1101);
    applyStimulus('0, 4);

    $display("[TB] random key activity");
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      col = $urandom_range(0, 3);
      r1  = $urandom_range(0, 3);
      r2  = (r1 + $urandom_range(1, 3)) % 4;
      case (sel)
        0:       keys = '0;
        2:       keys = keyBit(r1, col) | keyBit(r2, col);
        default: keys = keyBit(r1, col);
      endcase
      applyStimulus(keys, $urandom_range(1, 7));
    end
    applyStimulus('0, 5);
    checkOutput(mStrobe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Drives the 4x4 matrix keypad columns, samples the rows and debounces the result.
- Presents a stable `{rows, columns}` code to the downstream key decoder, which maps it to a 4-bit key value.
- Adds a level `key_valid` and a one-cycle `key_strobe` per debounced press, so the game logic consumes exactly one event per keystroke.

## Interface

Parameters
- `SCAN_DIV`, 50000: clock cycles per column dwell (one "tick" period). Legal range is 4..65535.
- `DEBOUNCE_CNT`, 8: consecutive matching ticks required to accept a press or a release. Legal range is 1..255.

Ports
- `clk`  in  1: system clock.
- `rst_n`  in  1: one clock; reset is synchronous and active-low.
- `row_in`  in  4: raw keypad row pins, active-low, asynchronous to `clk`.
- `col_out`  out  4: column drive, active-low one-hot.
- `rows`  out  4: debounced row code for the decoder, active-low one-hot.
- `columns`  out  4: debounced column code for the decoder, active-low one-hot.
- `key_valid`  out  1: high while the accepted key is held.
- `key_strobe`  out  1: one-cycle pulse on each accepted press.

## Operation

- `row_in` passes through a 2-FF synchronizer, giving `row_s`. All decisions use `row_s`.
- Divider counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when the count equals SCAN_DIV-1. The divider runs in every state.
- Column sequence: 1110 → 1101 → 1011 → 0111 → 1110. "Advance" means the new `col_out` appears the cycle after the tick.
- "Valid row" means `row_s` has exactly one 0 bit.
- States and transitions (all evaluated only on `tick`):
  - SCAN:
    - Valid row and DEBOUNCE_CNT==1: latch `rows`/`columns`, pulse strobe, go HELD.
    - Valid row otherwise: capture candidate = {row_s, col_out}, cnt=1, freeze column, go DEBOUNCE.
    - Otherwise (1111 or multiple zeros): advance column, stay in SCAN.
  - DEBOUNCE:
    - `row_s` equals candidate row: cnt+1. When cnt reaches DEBOUNCE_CNT, latch `rows`/`columns` from candidate, pulse strobe, set `key_valid`, go HELD.
    - Mismatch: advance column, go SCAN. No output change.
  - HELD:
    - Column stays frozen.
    - `row_s`==1111: rel_cnt+1.
    - Any other value: rel_cnt=0. A different row on the same column does not produce a new strobe.
    - When rel_cnt reaches DEBOUNCE_CNT: clear `key_valid`, advance column, go SCAN.
- `rows`/`columns` keep the last accepted key after release. They change only on acceptance.
- Only one key is tracked. Simultaneous presses in the same column (multiple zeros) are never accepted. Presses in other columns are invisible while the column is frozen.

## Timing

- Reset values, applied on the first `clk` edge with `rst_n`=0:
  - `col_out`=1110, `rows`=1111, `columns`=1111 (the decoder default, key 0).
  - `key_valid`=0, `key_strobe`=0.
  - State SCAN; divider, cnt and rel_cnt cleared; synchronizer = 1111.
- Reset mid-operation, including HELD or DEBOUNCE: the same values are applied. No strobe is emitted.
- Row settling: `row_s` is sampled SCAN_DIV-1 cycles after a column change. This leaves at least 1 settled cycle after the 2-cycle synchronizer, hence the SCAN_DIV≥4 limit.
- Press latency, from the detecting tick to acceptance: DEBOUNCE_CNT-1 further ticks. `rows`, `columns`, `key_valid` and `key_strobe` update in the same cycle, the cycle after the accepting tick.
- `key_strobe` is high exactly 1 cycle per accepted press.
- Release latency: DEBOUNCE_CNT ticks of `row_s`==1111. `key_valid` falls the cycle after the last of those ticks.
- Full scan of the keypad with no key pressed: 4·SCAN_DIV cycles.

## Test plan

Common bench setup:
- SCAN_DIV=4, DEBOUNCE_CNT=3.
- Behavioural keypad model: row r is pulled low iff key (r,c) is pressed and `col_out[c]`=0.

Scenarios:
1. Reset: hold `rst_n`=0 for 2 cycles with row_in=1111. Required: `col_out`=1110, `rows`=`columns`=1111, `key_valid`=`key_strobe`=0. After release `col_out` follows 1101, 1011, 0111, 1110, each held 4 cycles.
2. Clean press of key (row 1101, col 1011): Required: `rows`=1101, `columns`=1011, so the decoder shows 6. Exactly one `key_strobe` pulse arrives 2 ticks after the detecting tick, and `key_valid`=1.
3. Bounce: key (1110,1110) is low for 1 tick, then released. Required: no strobe, `rows`/`columns` unchanged, column scanning resumes.
4. Hold then release: key (0111,0111) held for 20 ticks, then released. Required: a single strobe and `rows`=0111, `columns`=0111 (decoder D). `key_valid` falls 3 ticks after release, and `rows`/`columns` retain 0111/0111.
5. Two keys pressed in the same column, giving row_s=1100 on col 1110. Required: never accepted, no strobe, `key_valid` stays 0.
6. Reset mid-HELD: pull `rst_n` low for 1 cycle while a key is held. Required: all reset values on the next edge and no strobe. If the key is still held, it is re-accepted with a new strobe 2 ticks after it is detected again.
